// File: rtl/wb_i2c_if.sv
// wb_i2c_if: I2C target with a Wishbone register port and RX/TX byte FIFOs.
// Ports: clk_i, rst_ni; Wishbone cyc_i stb_i we_i adr_i dat_i dat_o ack_o;
// I2C scl_i sda_i sense, sda_o open-drain drive (0 pulls low, 1 releases).
// Define WB_I2C_IF_IRQ_EN to add irq_o (RX non-empty or error flag set).
module wb_i2c_if #(
   parameter int                        WB_ADDR_WIDTH  = 2,
   parameter int                        WB_DATA_WIDTH  = 8,
   parameter int                        I2C_ADDR_WIDTH = 7,
   parameter int                        I2C_DATA_WIDTH = 8,
   parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
   parameter int                        FIFO_DEPTH     = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cyc_i,
   input  logic                     stb_i,
   input  logic                     we_i,
   input  logic [WB_ADDR_WIDTH-1:0] adr_i,
   input  logic [WB_DATA_WIDTH-1:0] dat_i,
   output logic [WB_DATA_WIDTH-1:0] dat_o,
   output logic                     ack_o,
   input  logic                     scl_i,
   input  logic                     sda_i,
   output logic                     sda_o
`ifdef WB_I2C_IF_IRQ_EN
   ,
   output logic                     irq_o
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
      S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
   } state_t;

   logic                      r_ack;
   logic [WB_DATA_WIDTH-1:0]  r_dat;
   logic [I2C_ADDR_WIDTH-1:0] r_saddr;
   logic                      r_tx_unf, r_rx_ovf;
   logic [1:0]                r_scl_s, r_sda_s;
   logic                      r_scl_d, r_sda_d;

   logic [I2C_DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
   logic [I2C_DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0]             r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
   logic [CW-1:0]             r_rx_cnt, r_tx_cnt;

   state_t                    r_state, w_state_n;
   logic [3:0]                r_bcnt, w_bcnt_n;
   logic [I2C_DATA_WIDTH-1:0] r_shift, w_shift_n;
   logic [I2C_DATA_WIDTH-1:0] r_txsh, w_txsh_n;
   logic                      r_sda, w_sda_n;
   logic                      r_ackd, w_ackd_n;
   logic                      r_busy, w_busy_n;
   logic                      r_last_op, w_last_n;

   logic w_wb_req, w_wr, w_rd;
   logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
   logic w_set_ovf, w_set_unf, w_load;
   logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [WB_DATA_WIDTH-1:0]  w_csr, w_rdata;
   logic [I2C_DATA_WIDTH-1:0] w_txbyte;

   assign w_wb_req   = cyc_i & stb_i & ~r_ack;
   assign w_wr       = w_wb_req & we_i;
   assign w_rd       = w_wb_req & ~we_i;
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
   assign w_rx_pop   = w_rd & (adr_i == 2'd2) & ~w_rx_empty;
   assign w_tx_push  = w_wr & (adr_i == 2'd1) & ~w_tx_full;
   assign w_txbyte   = w_tx_empty ? '1 : r_tx_mem[r_tx_rp];

   assign w_csr = {r_last_op, r_rx_ovf, r_tx_unf, r_busy,
                   w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

   always_comb begin
      w_rdata = '0;
      case (adr_i)
         2'd0:    w_rdata = w_csr;
         2'd2:    w_rdata = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
         2'd3:    w_rdata = {1'b0, r_saddr};
         default: w_rdata = '0;
      endcase
   end

   // Synchronized bus levels; START/STOP are SDA edges while SCL stays high.
   assign w_scl      = r_scl_s[1];
   assign w_sda      = r_sda_s[1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

   always_comb begin
      w_state_n = r_state;
      w_bcnt_n  = r_bcnt;
      w_shift_n = r_shift;
      w_txsh_n  = r_txsh;
      w_sda_n   = r_sda;
      w_ackd_n  = r_ackd;
      w_busy_n  = r_busy;
      w_last_n  = r_last_op;
      w_rx_push = 1'b0;
      w_tx_pop  = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      w_load    = 1'b0;
      if (w_stop) begin
         w_state_n = S_IDLE;
         w_sda_n   = 1'b1;
         w_busy_n  = 1'b0;
      end else if (w_start) begin
         w_state_n = S_ADDR;
         w_bcnt_n  = '0;
         w_sda_n   = 1'b1;
         w_ackd_n  = 1'b0;
      end else begin
         unique case (r_state)
            S_ADDR: if (w_scl_rise) begin
               w_shift_n = {r_shift[6:0], w_sda};
               w_bcnt_n  = r_bcnt + 4'd1;
               if (r_bcnt == 4'd7) begin
                  if (r_shift[6:0] == r_saddr) begin
                     w_state_n = S_ADDR_ACK;
                     w_last_n  = w_sda;
                     w_busy_n  = 1'b1;
                     w_ackd_n  = 1'b0;
                  end else begin
                     w_state_n = S_IGNORE;
                  end
               end
            end
            // First fall drives ACK, second fall ends the ACK clock.
            S_ADDR_ACK: if (w_scl_fall) begin
               if (!r_ackd) begin
                  w_sda_n  = 1'b0;
                  w_ackd_n = 1'b1;
               end else if (r_last_op) begin
                  w_state_n = S_RD_BYTE;
                  w_load    = 1'b1;
               end else begin
                  w_state_n = S_WR_BYTE;
                  w_sda_n   = 1'b1;
                  w_bcnt_n  = '0;
               end
            end
            S_WR_BYTE: if (w_scl_rise) begin
               w_shift_n = {r_shift[6:0], w_sda};
               w_bcnt_n  = r_bcnt + 4'd1;
               if (r_bcnt == 4'd7) begin
                  w_state_n = S_WR_ACK;
                  w_ackd_n  = 1'b0;
               end
            end
            S_WR_ACK: if (w_scl_fall) begin
               if (!r_ackd) begin
                  w_ackd_n = 1'b1;
                  if (!w_rx_full) begin
                     w_rx_push = 1'b1;
                     w_sda_n   = 1'b0;
                  end else begin
                     w_set_ovf = 1'b1;
                  end
               end else begin
                  w_state_n = S_WR_BYTE;
                  w_sda_n   = 1'b1;
                  w_bcnt_n  = '0;
               end
            end
            // bcnt counts bits already driven; 0 means fetch a new byte.
            S_RD_BYTE: if (w_scl_fall) begin
               if (r_bcnt == 4'd0) begin
                  w_load = 1'b1;
               end else if (r_bcnt == 4'd8) begin
                  w_state_n = S_RD_ACK;
                  w_sda_n   = 1'b1;
               end else begin
                  w_sda_n  = r_txsh[7];
                  w_txsh_n = {r_txsh[6:0], 1'b1};
                  w_bcnt_n = r_bcnt + 4'd1;
               end
            end
            S_RD_ACK: if (w_scl_rise) begin
               w_state_n = w_sda ? S_IGNORE : S_RD_BYTE;
               w_bcnt_n  = '0;
            end
            default: ;
         endcase
         if (w_load) begin
            w_tx_pop  = ~w_tx_empty;
            w_set_unf = w_tx_empty;
            w_sda_n   = w_txbyte[7];
            w_txsh_n  = {w_txbyte[6:0], 1'b1};
            w_bcnt_n  = 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_bcnt    <= '0;
         r_shift   <= '0;
         r_txsh    <= '0;
         r_sda     <= 1'b1;
         r_ackd    <= 1'b0;
         r_busy    <= 1'b0;
         r_last_op <= 1'b0;
         r_scl_s   <= 2'b11;
         r_sda_s   <= 2'b11;
         r_scl_d   <= 1'b1;
         r_sda_d   <= 1'b1;
      end else begin
         r_state   <= w_state_n;
         r_bcnt    <= w_bcnt_n;
         r_shift   <= w_shift_n;
         r_txsh    <= w_txsh_n;
         r_sda     <= w_sda_n;
         r_ackd    <= w_ackd_n;
         r_busy    <= w_busy_n;
         r_last_op <= w_last_n;
         r_scl_s   <= {r_scl_s[0], scl_i};
         r_sda_s   <= {r_sda_s[0], sda_i};
         r_scl_d   <= r_scl_s[1];
         r_sda_d   <= r_sda_s[1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_saddr  <= SLAVE_ADDR;
         r_tx_unf <= 1'b0;
         r_rx_ovf <= 1'b0;
      end else begin
         r_ack <= w_wb_req;
         if (w_wb_req)
            r_dat <= we_i ? '0 : w_rdata;
         if (w_wr && adr_i == 2'd3)
            r_saddr <= dat_i[I2C_ADDR_WIDTH-1:0];
         if (w_set_unf)
            r_tx_unf <= 1'b1;
         else if (w_wr && adr_i == 2'd0 && dat_i[5])
            r_tx_unf <= 1'b0;
         if (w_set_ovf)
            r_rx_ovf <= 1'b1;
         else if (w_wr && adr_i == 2'd0 && dat_i[6])
            r_rx_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
         else if (w_rx_pop && !w_rx_push) r_rx_cnt <= r_rx_cnt - 1'b1;
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
         if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
         else if (w_tx_pop && !w_tx_push) r_tx_cnt <= r_tx_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= r_shift;
      if (w_tx_push) r_tx_mem[r_tx_wp] <= dat_i;
   end

   assign dat_o = r_dat;
   assign ack_o = r_ack;
   assign sda_o = r_sda;

`ifdef WB_I2C_IF_IRQ_EN
   logic r_irq;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_irq <= 1'b0;
      else         r_irq <= ~w_rx_empty | r_tx_unf | r_rx_ovf;
   end
   assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_wb_i2c_if.sv
// tb_wb_i2c_if: directed plus random I2C master / Wishbone host bench.
// Expectations come from a queue-based model of the target's FIFOs and flags.
`timescale 1ns/1ps
module tb_wb_i2c_if;
   localparam int Q = 30;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [1:0] adr = '0;
   logic [7:0] dati = '0;
   logic [7:0] dato;
   logic       ack;
   logic       scl_m = 1'b1, sda_m = 1'b1;
   logic       sda_o;
   logic       sda_line;
`ifdef WB_I2C_IF_IRQ_EN
   logic       irq;
`endif

   assign sda_line = sda_m & sda_o;

   always #5 clk = ~clk;

   wb_i2c_if dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .cyc_i  (cyc),
      .stb_i  (stb),
      .we_i   (we),
      .adr_i  (adr),
      .dat_i  (dati),
      .dat_o  (dato),
      .ack_o  (ack),
      .scl_i  (scl_m),
      .sda_i  (sda_line),
      .sda_o  (sda_o)
`ifdef WB_I2C_IF_IRQ_EN
      ,
      .irq_o  (irq)
`endif
   );

   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   logic       m_unf = 1'b0, m_ovf = 1'b0, m_last = 1'b0;
   logic [6:0] m_sa = 7'h22;
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_csr();
      return {m_last, m_ovf, m_unf, 1'b0,
              tx_q.size() == 32, tx_q.size() == 0,
              rx_q.size() == 32, rx_q.size() == 0};
   endfunction

   task automatic wb_cyc(input logic w, input logic [1:0] a,
                         input logic [7:0] d, output logic [7:0] q);
      int n;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = d;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (ack !== 1'b1 && n < 8);
      q = dato;
      chk("wb_ack", ack, 8'h01);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_push(input logic [7:0] d);
      logic [7:0] q;
      wb_cyc(1'b1, 2'd1, d, q);
      if (tx_q.size() < 32) tx_q.push_back(d);
   endtask

   task automatic wb_pop();
      logic [7:0] q, e;
      wb_cyc(1'b0, 2'd2, 8'h00, q);
      e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      chk("rxdata", q, e);
   endtask

   task automatic chk_csr(input string tag);
      logic [7:0] q;
      wb_cyc(1'b0, 2'd0, 8'h00, q);
      chk(tag, q, exp_csr());
   endtask

   task automatic csr_wr(input logic [7:0] d);
      logic [7:0] q;
      wb_cyc(1'b1, 2'd0, d, q);
      if (d[5]) m_unf = 1'b0;
      if (d[6]) m_ovf = 1'b0;
   endtask

   task automatic bit_w(input logic b);
      #Q sda_m = b;
      #Q scl_m = 1'b1;
      #(2*Q) scl_m = 1'b0;
   endtask

   task automatic bit_r(output logic b);
      #Q sda_m = 1'b1;
      #Q scl_m = 1'b1;
      #Q b = sda_line;
      #Q scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; scl_m = 1'b1;
      #Q sda_m = 1'b0;
      #Q scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      #Q sda_m = 1'b0;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b1;
      #Q;
   endtask

   task automatic byte_w(input logic [7:0] d, output logic ak);
      logic b;
      for (int i = 7; i >= 0; i--) bit_w(d[i]);
      bit_r(b);
      ak = ~b;
   endtask

   task automatic byte_r(input logic ak, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_r(b);
         d[i] = b;
      end
      bit_w(~ak);
   endtask

   task automatic mwrite(input logic [6:0] a, input logic [7:0] d);
      logic ak, ea;
      logic match;
      match = (a == m_sa);
      i2c_start();
      byte_w({a, 1'b0}, ak);
      chk("addr_ack_w", ak, match);
      if (match) begin
         m_last = 1'b0;
         byte_w(d, ak);
         ea = (rx_q.size() < 32);
         chk("data_ack", ak, ea);
         if (ea) rx_q.push_back(d);
         else    m_ovf = 1'b1;
      end
      i2c_stop();
   endtask

   task automatic mread(input logic [6:0] a, input int n);
      logic       ak;
      logic       match;
      logic [7:0] d, e;
      match = (a == m_sa);
      i2c_start();
      byte_w({a, 1'b1}, ak);
      chk("addr_ack_r", ak, match);
      if (match) begin
         m_last = 1'b1;
         for (int i = 0; i < n; i++) begin
            byte_r(i < n - 1, d);
            if (tx_q.size() > 0) e = tx_q.pop_front();
            else begin
               e = 8'hFF;
               m_unf = 1'b1;
            end
            chk("rd_data", d, e);
         end
      end
      i2c_stop();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] q;
      logic       b, ak;
      int         op;

      repeat (5) @(posedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      chk("reset_sda", sda_o, 8'h01);
      chk_csr("reset_csr");
      wb_cyc(1'b0, 2'd3, 8'h00, q);
      chk("reset_saddr", q, 8'h22);

      for (int i = 0; i < 32; i++) mwrite(7'h22, 8'(i));
      chk_csr("rx_full_csr");
      for (int i = 0; i < 32; i++) wb_pop();
      chk_csr("rx_drained_csr");

      for (int i = 0; i < 32; i++) wb_push(8'(100 + i));
      chk_csr("tx_full_csr");
      mread(7'h22, 32);
      chk_csr("tx_drained_csr");

      for (int i = 0; i < 64; i++) begin
         wb_push(8'(63 - i));
         mwrite(7'h22, 8'(64 + i));
         chk_csr("alt_w_csr");
         mread(7'h22, 1);
         chk_csr("alt_r_csr");
         wb_pop();
      end

      wb_push(8'hC3);
      mwrite(7'h23, 8'hAA);
      mread(7'h23, 1);
      chk_csr("wrong_addr_csr");
      for (int i = 0; i < 33; i++) mwrite(7'h22, 8'($urandom));
      chk_csr("overflow_csr");
      csr_wr(8'h40);
      chk_csr("ovf_clear_csr");
      for (int i = 0; i < 32; i++) wb_pop();

      mread(7'h22, 1);
      mread(7'h22, 1);
      chk_csr("underflow_csr");
      csr_wr(8'h20);
      chk_csr("unf_clear_csr");

      wb_cyc(1'b1, 2'd3, 8'hD5, q);
      m_sa = 7'h55;
      wb_cyc(1'b0, 2'd3, 8'h00, q);
      chk("saddr_rw", q, 8'h55);
      mwrite(7'h55, 8'h3C);
      mwrite(7'h22, 8'h3D);
      wb_pop();
      wb_cyc(1'b1, 2'd3, 8'h22, q);
      m_sa = 7'h22;

      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 5));
         case (op)
            0: wb_push(8'($urandom));
            1: mwrite(($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h22,
                      8'($urandom));
            2: mread(7'h22, int'($urandom_range(1, 3)));
            3: wb_pop();
            4: csr_wr(8'($urandom));
            default: chk_csr("rand_csr");
         endcase
      end
      chk_csr("rand_end_csr");

      if (tx_q.size() > 0) mread(7'h22, tx_q.size());
      csr_wr(8'h60);
      wb_push(8'h00);
      i2c_start();
      byte_w(8'h45, ak);
      chk("mid_addr_ack", ak, 8'h01);
      bit_r(b);
      bit_r(b);
      #Q;
      chk("mid_drive_low", sda_o, 8'h00);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_sda", sda_o, 8'h01);
      rx_q.delete();
      tx_q.delete();
      m_unf = 1'b0; m_ovf = 1'b0; m_last = 1'b0; m_sa = 7'h22;
      repeat (3) @(posedge clk);
      rst_n = 1'b1;
      i2c_stop();
      chk_csr("post_reset_csr");
      mwrite(7'h22, 8'h5A);
      wb_pop();
      chk_csr("final_csr");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
